// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, fetch FSM state encodings and the prefetch
//               queue entry type for the 5-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Fetch FSM encodings
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  // One prefetch queue slot: the address a word was fetched from and the word
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps modulo 2^32
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small synchronous FIFO for prefetched {pc, instr} pairs.
//               Clear wins over push and pop; head is the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push;
  logic w_pop;

  // A pop on an empty queue is ignored so the count can never underflow
  assign w_push  = push_i && !clear_i;
  assign w_pop   = pop_i && !clear_i && (r_count != '0);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  // Storage write; data needs no reset because count gates visibility
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues req/ack requests
//               to instruction memory, buffers returned words in a prefetch
//               queue and presents the queue head to IF/ID. Handles stalls,
//               branch redirects and the IF/ID flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        flush_o
);

  localparam int            CW      = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(QDEPTH);

  logic [1:0]    r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;

  logic          w_branch;
  logic [31:0]   w_target;
  logic          w_xfer;
  logic          w_push;
  logic          w_pop;
  logic          w_space;
  logic          w_space_after;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_empty;
  logic [63:0]   w_head_raw;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;

  // A redirect only counts while the pipeline is running
  assign w_branch = branch_i && start_i;
  assign w_target = branch_target_i & ~32'h0000_0003;
  assign flush_o  = w_branch;

  assign imem_req_o  = (r_state == S_FETCH) || (r_state == S_DISCARD);
  assign imem_addr_o = r_req_addr;
  assign w_xfer      = imem_req_o && imem_ack_i;

  // Data returned in FETCH is kept unless a redirect lands in the same cycle;
  // with start_i low the in-flight word is still pushed
  assign w_push = (r_state == S_FETCH) && w_xfer && !w_branch;
  assign w_pop  = valid_o && !stall_i && start_i && !branch_i;

  assign w_push_entry.pc    = r_req_addr;
  assign w_push_entry.instr = imem_data_i;

  // Occupancy now and after this cycle's push/pop decides further requests
  assign w_space       = (w_count < C_DEPTH);
  assign w_count_nxt   = w_count + CW'(w_push) - CW'(w_pop);
  assign w_space_after = (w_count_nxt < C_DEPTH);

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (64)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (w_branch),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .count_o (w_count),
    .head_o  (w_head_raw),
    .empty_o (w_empty)
  );

  assign w_head  = fetch_entry_t'(w_head_raw);
  assign valid_o = !w_empty;
  assign pc_o    = valid_o ? w_head.pc    : r_fetch_pc;
  assign instr_o = valid_o ? w_head.instr : NOP_INSTR;

  // Fetch sequencing: request issue, back-to-back streaming and redirects
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_branch) begin
            r_fetch_pc <= w_target;
          end else if (start_i && w_space) begin
            r_state    <= S_FETCH;
            r_req_addr <= r_fetch_pc;
          end
        end
        S_FETCH: begin
          if (w_xfer) begin
            if (w_branch) begin
              r_fetch_pc <= w_target;
              r_state    <= S_IDLE;
            end else begin
              r_fetch_pc <= next_pc(r_req_addr);
              if (start_i && w_space_after) begin
                r_req_addr <= next_pc(r_req_addr);
              end else begin
                r_state <= S_IDLE;
              end
            end
          end else if (w_branch) begin
            // The request cannot be withdrawn; let it finish and drop it
            r_fetch_pc <= w_target;
            r_state    <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (w_branch) begin
            r_fetch_pc <= w_target;
          end
          if (w_xfer) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        valid;
  logic        flush;

  int          lat;
  int          wcnt;
  int          n_checks;
  int          n_errors;

  localparam logic [31:0] C_PAT = 32'hA5A5_A5A5;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (target),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_ack_i      (ack),
    .imem_data_i     (data),
    .pc_o            (pc),
    .instr_o         (instr),
    .valid_o         (valid),
    .flush_o         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after `lat` wait cycles, data = address ^ pattern
  assign ack  = req && (wcnt >= lat);
  assign data = addr ^ C_PAT;

  always @(posedge clk) begin
    if (!req || ack) wcnt <= 0;
    else             wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wcnt     = 0;
    lat      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    stall    = 1'b0;
    branch   = 1'b0;
    target   = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_req",   {31'h0, req},   32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_instr", instr,          32'h0);
    chk("rst_pc",    pc,             32'h0);

    // Streaming with same-cycle ack
    rst = 1'b0; start = 1'b1; #1;
    chk("idle_req", {31'h0, req}, 32'h0);
    tick();
    chk("c1_valid", {31'h0, valid}, 32'h0);
    chk("c1_req",   {31'h0, req},   32'h1);
    chk("c1_addr",  addr,           32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", {31'h0, valid}, 32'h1);
      chk("stream_pc",    pc,    32'(i * 4));
      chk("stream_instr", instr, 32'(i * 4) ^ C_PAT);
      if (i < 3) tick();
    end

    // Stall for 3 cycles; queue fills and requests stop
    stall = 1'b1;
    tick();
    chk("stall1_pc",  pc,           32'hC);
    chk("stall1_req", {31'h0, req}, 32'h0);
    tick();
    chk("stall2_pc",    pc,           32'hC);
    chk("stall2_instr", instr,        32'h0000_000C ^ C_PAT);
    chk("stall2_req",   {31'h0, req}, 32'h0);
    tick();
    stall = 1'b0; #1;
    chk("unstall_pc", pc, 32'hC);
    tick();
    chk("resume_pc",  pc,           32'h10);
    chk("resume_req", {31'h0, req}, 32'h0);
    tick();
    chk("refetch_valid", {31'h0, valid}, 32'h0);
    chk("refetch_req",   {31'h0, req},   32'h1);
    chk("refetch_addr",  addr,           32'h14);
    tick();
    chk("resume_pc14", pc, 32'h14);
    tick();
    chk("resume_pc18", pc,   32'h18);
    chk("stream_addr", addr, 32'h1C);

    // Branch with two queued entries
    stall = 1'b1;
    tick();
    chk("full_pc",    pc,             32'h18);
    chk("full_valid", {31'h0, valid}, 32'h1);
    chk("full_req",   {31'h0, req},   32'h0);
    branch = 1'b1; target = 32'h0000_0102; #1;
    chk("br_flush", {31'h0, flush}, 32'h1);
    tick();
    branch = 1'b0; stall = 1'b0; #1;
    chk("br_valid",   {31'h0, valid}, 32'h0);
    chk("br_noflush", {31'h0, flush}, 32'h0);
    chk("br_req",     {31'h0, req},   32'h0);
    tick();
    chk("br_fetch_req",  {31'h0, req}, 32'h1);
    chk("br_fetch_addr", addr,         32'h100);
    tick();
    chk("br_pc",    pc,    32'h100);
    chk("br_instr", instr, 32'h0000_0100 ^ C_PAT);

    // Reset mid-FETCH with a queued entry; then slow memory
    rst = 1'b1; lat = 3;
    tick();
    chk("mrst_req",   {31'h0, req},   32'h0);
    chk("mrst_valid", {31'h0, valid}, 32'h0);
    chk("mrst_pc",    pc,             32'h0);
    chk("mrst_instr", instr,          32'h0);
    rst = 1'b0;
    tick();
    chk("slow_req",  {31'h0, req}, 32'h1);
    chk("slow_addr", addr,         32'h0);
    tick();
    branch = 1'b1; target = 32'h0000_0200; #1;
    chk("wait_br_flush", {31'h0, flush}, 32'h1);
    tick();
    branch = 1'b0; #1;
    chk("disc_req",   {31'h0, req},   32'h1);
    chk("disc_addr",  addr,           32'h0);
    chk("disc_valid", {31'h0, valid}, 32'h0);
    tick();
    chk("disc_ack_addr", addr,         32'h0);
    chk("disc_ack",      {31'h0, ack}, 32'h1);
    tick();
    chk("disc_done_req",   {31'h0, req},   32'h0);
    chk("disc_done_valid", {31'h0, valid}, 32'h0);
    tick();
    chk("tgt_req",  {31'h0, req}, 32'h1);
    chk("tgt_addr", addr,         32'h200);

    // start dropped while the request is outstanding
    tick();
    start = 1'b0; #1;
    chk("nostart_req", {31'h0, req}, 32'h1);
    tick();
    tick();
    chk("nostart_addr", addr, 32'h200);
    tick();
    chk("hold_valid", {31'h0, valid}, 32'h1);
    chk("hold_pc",    pc,             32'h200);
    chk("hold_instr", instr,          32'hA5A5_A7A5);
    chk("hold_req",   {31'h0, req},   32'h0);
    tick();
    chk("hold2_pc",  pc,           32'h200);
    chk("hold2_req", {31'h0, req}, 32'h0);
    tick();
    start = 1'b1; #1;
    chk("restart_pc", pc, 32'h200);
    tick();
    chk("restart_valid", {31'h0, valid}, 32'h0);
    chk("restart_req",   {31'h0, req},   32'h1);
    chk("restart_addr",  addr,           32'h204);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
